serial_nibble_link: RTL and testbench

Parallel-to-serial nibble link in two halves. The transmitter (m1 role) latches a 4-bit word and sends it MSB-first on a two-wire scl/sda bus using start and stop conditions. The receiver (m2 role) monitors the same wires and decodes each complete frame into a 16-bit one-hot word. The block sits between a word source, handshaked by `ack`, and a one-hot consumer; scl/sda are exported for observation.

---
 rtl/serial_nibble_link_if.sv | 24 ++
 rtl/serial_nibble_link.sv | 137 +++++++++++++
 tb/tb_serial_nibble_link.sv | 135 +++++++++++++
 3 files changed

// File: rtl/serial_nibble_link_if.sv
// Word-source / one-hot-consumer bus of serial_nibble_link, including the observable scl/sda pair.
interface serial_nibble_link_if;
  logic [3:0]  date;
  logic        ack;
  logic        scl;
  logic        sda;
  logic [15:0] outhigh;

  modport master (
    input  date,
    output ack,
    output scl,
    output sda,
    output outhigh
  );

  modport slave (
    output date,
    input  ack,
    input  scl,
    input  sda,
    input  outhigh
  );
endinterface

// File: rtl/serial_nibble_link.sv
// Nibble link: latches a 4-bit word, sends it MSB-first on scl/sda framed by start/stop, and decodes
// each frame to one-hot. Optional SERIAL_LINK_CLEAR_ON_START_EN clears outhigh on every start.
module serial_nibble_link (
  input  logic                 sclk,
  input  logic                 rst,
  serial_nibble_link_if.master bus
);

  typedef enum logic [2:0] {
    StLoad, StStart, StBit3, StBit2, StBit1, StBit0, StStop
  } tx_state_e;

  logic [1:0]  p_q;
  tx_state_e   state_q, state_d;
  logic        ack_q, ack_d;
  logic        sda_q, sda_d;
  logic [3:0]  data_q, data_d;
  logic        scl;
  logic        mid_high, mid_low;

  logic        scl_d_q, sda_d_q;
  logic        armed_q, armed_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  sr_q, sr_d;
  logic [15:0] outhigh_q, outhigh_d;
  logic        start_det, stop_det, bit_det;

  assign scl      = ~p_q[1];
  assign mid_high = (p_q == 2'd0);
  assign mid_low  = (p_q == 2'd2);

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      p_q     <= 2'd0;
      state_q <= StLoad;
      ack_q   <= 1'b0;
      sda_q   <= 1'b1;
      data_q  <= 4'h0;
    end else begin
      p_q     <= p_q + 2'd1;
      state_q <= state_d;
      ack_q   <= ack_d;
      sda_q   <= sda_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    sda_d   = sda_q;
    data_d  = data_q;
    unique case (state_q)
      StLoad: begin
        if (mid_high) begin
          ack_d   = 1'b1;
          data_d  = bus.date;
          state_d = StStart;
        end
      end
      // sda low marks that the start condition has already been issued in this state.
      StStart: begin
        if (mid_high) begin
          sda_d = 1'b0;
        end else if (mid_low && !sda_q) begin
          sda_d   = data_q[3];
          state_d = StBit3;
        end
      end
      StBit3: if (mid_low) begin sda_d = data_q[2]; state_d = StBit2; end
      StBit2: if (mid_low) begin sda_d = data_q[1]; state_d = StBit1; end
      StBit1: if (mid_low) begin sda_d = data_q[0]; state_d = StBit0; end
      StBit0: if (mid_low) begin sda_d = 1'b0;      state_d = StStop; end
      StStop: begin
        if (mid_high) begin
          sda_d   = 1'b1;
          ack_d   = 1'b1;
          data_d  = bus.date;
          state_d = StStart;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  assign start_det = scl_d_q & scl & sda_d_q & ~sda_q;
  assign stop_det  = scl_d_q & scl & ~sda_d_q & sda_q;
  assign bit_det   = ~scl_d_q & scl & armed_q;

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      scl_d_q   <= 1'b1;
      sda_d_q   <= 1'b1;
      armed_q   <= 1'b0;
      cnt_q     <= 3'd0;
      sr_q      <= 4'h0;
      outhigh_q <= 16'h0000;
    end else begin
      scl_d_q   <= scl;
      sda_d_q   <= sda_q;
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      outhigh_q <= outhigh_d;
    end
  end

  always_comb begin
    armed_d   = armed_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    outhigh_d = outhigh_q;
    if (start_det) begin
      armed_d = 1'b1;
      cnt_d   = 3'd0;
      sr_d    = 4'h0;
`ifdef SERIAL_LINK_CLEAR_ON_START_EN
      outhigh_d = 16'h0000;
`else
      outhigh_d = outhigh_q;
`endif
    end else if (stop_det) begin
      if (armed_q && (cnt_q == 3'd4)) outhigh_d = 16'h0001 << sr_q;
      armed_d = 1'b0;
    end else if (bit_det && (cnt_q < 3'd4)) begin
      // The scl rise of the stop period precedes the stop condition and carries no data.
      sr_d  = {sr_q[2:0], sda_q};
      cnt_d = cnt_q + 3'd1;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.scl     = scl;
  assign bus.sda     = sda_q;
  assign bus.outhigh = outhigh_q;

endmodule

// File: tb/tb_serial_nibble_link.sv
// Directed bench for serial_nibble_link: per-edge protocol checks plus a one-hot scoreboard.
module tb_serial_nibble_link;

  logic sclk;
  logic rst;
  serial_nibble_link_if bus ();

  serial_nibble_link dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          e = 0;
  logic        src_inc = 1'b0;
  logic [3:0]  tx_word = 4'h0;
  logic [15:0] exp_oh = 16'h0000;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic [15:0] sb[$];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s at edge %0d: observed %h expected %h", tag, e, got, want);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"}, {15'h0, bus.ack}, 16'h0);
    chk({tag, "_scl"}, {15'h0, bus.scl}, 16'h1);
    chk({tag, "_sda"}, {15'h0, bus.sda}, 16'h1);
    chk({tag, "_outhigh"}, bus.outhigh, 16'h0000);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge sclk);
    chk_reset_vals("reset");
    rst = 1'b1;
    e = 0;
    sb.delete();
    exp_oh = 16'h0000;
    prev_scl = 1'b1;
    prev_sda = 1'b1;
  endtask

  // One sclk edge: sample 1 time unit after the rising edge and check everything due there.
  task automatic step();
    int          m;
    logic [15:0] want;
    @(posedge sclk);
    #1;
    e++;
    m = e % 24;
    chk("scl", {15'h0, bus.scl}, {15'h0, ((e % 4) < 2)});
    chk("ack", {15'h0, bus.ack}, {15'h0, (m == 1)});
    if (m == 1) begin
      sb.push_back(16'h0001 << bus.date);
      tx_word = bus.date;
    end
    if (m == 5) chk("start_sda", {15'h0, bus.sda}, 16'h0);
    if (m == 1 && e > 1) chk("stop_sda", {15'h0, bus.sda}, 16'h1);
    if (m == 9 || m == 13 || m == 17 || m == 21)
      chk("data_bit", {15'h0, bus.sda}, {15'h0, tx_word[3 - (m - 9) / 4]});
    if (bus.scl && prev_scl && (bus.sda !== prev_sda))
      chk("sda_while_scl_high", {15'h0, (m == 1 || m == 5)}, 16'h1);
`ifdef SERIAL_LINK_CLEAR_ON_START_EN
    if (m == 6) exp_oh = 16'h0000;
`endif
    if (m == 2 && e >= 26) begin
      chk("sb_nonempty", {15'h0, (sb.size() != 0)}, 16'h1);
      if (sb.size() != 0) begin
        want = sb.pop_front();
        chk("outhigh_frame", bus.outhigh, want);
        exp_oh = want;
      end
    end else begin
      chk("outhigh_hold", bus.outhigh, exp_oh);
    end
    prev_scl = bus.scl;
    prev_sda = bus.sda;
    // Source presents the next word 28 time units after the ack rise.
    if (src_inc && m == 3) begin
      #7;
      bus.date = bus.date + 4'h1;
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.date = 4'h0;

    // Incrementing source: one-hot walks 0x0001..0x8000 and wraps to 0x0001.
    do_reset();
    src_inc = 1'b1;
    repeat (18 * 24 + 2) step();
    src_inc = 1'b0;

    // 4'hA captured at edge 25: bits 1,0,1,0 and outhigh 0x0400 at edge 50.
    bus.date = 4'h0;
    do_reset();
    step();
    step();
    bus.date = 4'hA;
    repeat (61) step();
    chk("outhigh_0400", bus.outhigh, 16'h0400);

    // Reset asserted mid-frame acts asynchronously, before the next clock edge.
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    bus.date = 4'h5;
    do_reset();
    repeat (52) step();
    chk("outhigh_after_restart", bus.outhigh, 16'h0020);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
